// File: rtl/traffic_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// traffic_input_conditioner_if
// Raw field inputs and conditioned outputs of the traffic input conditioner.
// Revision: 1.0
// ============================================================================
interface traffic_input_conditioner_if;
  logic       car_sensor_raw;
  logic       pedestrian_btn_raw;
  logic       emergency_raw;
  logic       car_enter_raw;
  logic       car_exit_raw;
  logic       low_traffic_raw;
  logic       ped_served;
  logic       car_sensor;
  logic       pedestrian_req;
  logic       emergency;
  logic       car_enter;
  logic       car_exit;
  logic       low_traffic_mode;
  logic [7:0] emergency_count;

  modport master (
    output car_sensor_raw, pedestrian_btn_raw, emergency_raw,
    output car_enter_raw, car_exit_raw, low_traffic_raw, ped_served,
    input  car_sensor, pedestrian_req, emergency, car_enter, car_exit,
    input  low_traffic_mode, emergency_count
  );

  modport slave (
    input  car_sensor_raw, pedestrian_btn_raw, emergency_raw,
    input  car_enter_raw, car_exit_raw, low_traffic_raw, ped_served,
    output car_sensor, pedestrian_req, emergency, car_enter, car_exit,
    output low_traffic_mode, emergency_count
  );
endinterface
`default_nettype wire

// File: rtl/traffic_input_conditioner.sv
`default_nettype none
// ============================================================================
// traffic_input_conditioner
// Synchronise/debounce field inputs; pedestrian and emergency request logic.
// Optional macro TRAFFIC_STATS_EN enables the saturating emergency counter.
// Revision: 1.0
// ============================================================================
module traffic_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int EMERG_HOLD      = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  traffic_input_conditioner_if.slave  tic
);
  localparam int         c_NCH       = 6;
  localparam int         c_CH_CAR    = 0;
  localparam int         c_CH_PED    = 1;
  localparam int         c_CH_EMG    = 2;
  localparam int         c_CH_ENTER  = 3;
  localparam int         c_CH_EXIT   = 4;
  localparam int         c_CH_LOW    = 5;
  localparam logic [3:0] c_DB_LAST   = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] c_HOLD_LOAD = 8'(EMERG_HOLD - 1);

  localparam logic [1:0] P_IDLE    = 2'd0;
  localparam logic [1:0] P_PENDING = 2'd1;
  localparam logic [1:0] P_SERVING = 2'd2;

  localparam logic [1:0] E_IDLE    = 2'd0;
  localparam logic [1:0] E_HOLD    = 2'd1;
  localparam logic [1:0] E_TRACK   = 2'd2;

  logic [c_NCH-1:0] w_raw;
  logic [c_NCH-1:0] sync1_q;
  logic [c_NCH-1:0] sync2_q;
  logic [c_NCH-1:0] w_clean;
  logic [c_NCH-1:0] w_rise;

  assign w_raw = {tic.low_traffic_raw, tic.car_exit_raw, tic.car_enter_raw,
                  tic.emergency_raw, tic.pedestrian_btn_raw, tic.car_sensor_raw};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= w_raw;
      sync2_q <= sync1_q;
    end
  end

  // w_rise marks the edge on which a channel's clean level goes high.
  for (genvar g = 0; g < c_NCH; g++) begin : g_debounce
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       clean_q;
    logic       clean_d;
    logic       w_done;

    assign w_done = (sync2_q[g] != clean_q) && (cnt_q == c_DB_LAST);

    always_comb begin
      cnt_d   = 4'd0;
      clean_d = clean_q;
      if (w_done) begin
        clean_d = sync2_q[g];
      end else if (sync2_q[g] != clean_q) begin
        cnt_d = cnt_q + 4'd1;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q   <= 4'd0;
        clean_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        clean_q <= clean_d;
      end
    end

    assign w_clean[g] = clean_q;
    assign w_rise[g]  = w_done & sync2_q[g];
  end

  logic enter_q;
  logic exit_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
    end else begin
      enter_q <= w_rise[c_CH_ENTER] & ~w_rise[c_CH_EXIT];
      exit_q  <= w_rise[c_CH_EXIT]  & ~w_rise[c_CH_ENTER];
    end
  end

  // Pedestrian request handshake
  logic [1:0] ped_state_q;
  logic [1:0] ped_state_d;
  logic       w_ped_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ped_state_q <= P_IDLE;
    else          ped_state_q <= ped_state_d;
  end

  always_comb begin
    ped_state_d = ped_state_q;
    case (ped_state_q)
      P_IDLE:    if (w_rise[c_CH_PED]) ped_state_d = P_PENDING;
      P_PENDING: if (tic.ped_served)   ped_state_d = P_SERVING;
      P_SERVING: if (!tic.ped_served)  ped_state_d = P_IDLE;
      default:                         ped_state_d = P_IDLE;
    endcase
  end

  always_comb begin
    w_ped_req = (ped_state_q == P_PENDING);
  end

  // Emergency qualification with minimum hold
  logic [1:0] emg_state_q;
  logic [1:0] emg_state_d;
  logic [7:0] hold_q;
  logic [7:0] hold_d;
  logic       w_emergency;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      emg_state_q <= E_IDLE;
      hold_q      <= 8'd0;
    end else begin
      emg_state_q <= emg_state_d;
      hold_q      <= hold_d;
    end
  end

  always_comb begin
    emg_state_d = emg_state_q;
    hold_d      = hold_q;
    case (emg_state_q)
      E_IDLE: begin
        if (w_rise[c_CH_EMG]) begin
          emg_state_d = E_HOLD;
          hold_d      = c_HOLD_LOAD;
        end
      end
      E_HOLD: begin
        if (hold_q == 8'd0) emg_state_d = w_clean[c_CH_EMG] ? E_TRACK : E_IDLE;
        else                hold_d      = hold_q - 8'd1;
      end
      E_TRACK: if (!w_clean[c_CH_EMG]) emg_state_d = E_IDLE;
      default: emg_state_d = E_IDLE;
    endcase
  end

  always_comb begin
    w_emergency = (emg_state_q != E_IDLE);
  end

`ifdef TRAFFIC_STATS_EN
  logic [7:0] emg_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      emg_count_q <= 8'd0;
    end else if ((emg_state_q == E_IDLE) && w_rise[c_CH_EMG] && (emg_count_q != 8'hFF)) begin
      emg_count_q <= emg_count_q + 8'd1;
    end
  end

  assign tic.emergency_count = emg_count_q;
`else
  assign tic.emergency_count = 8'd0;
`endif

  assign tic.car_sensor       = w_clean[c_CH_CAR];
  assign tic.low_traffic_mode = w_clean[c_CH_LOW];
  assign tic.car_enter        = enter_q;
  assign tic.car_exit         = exit_q;
  assign tic.pedestrian_req   = w_ped_req;
  assign tic.emergency        = w_emergency;

endmodule
`default_nettype wire

// File: tb/tb_traffic_input_conditioner.sv
`default_nettype none
// Testbench for traffic_input_conditioner: table vectors, directed corner cases and
// randomized traffic compared cycle by cycle against a behavioural model.
module tb_traffic_input_conditioner;
  localparam int DB = 3;
  localparam int EH = 8;
  localparam logic [14:0] DB_MASK = 15'((1 << DB) - 1);
`ifdef TRAFFIC_STATS_EN
  localparam int EXP_FINAL_CNT = 255;
`else
  localparam int EXP_FINAL_CNT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] raw = 6'd0;
  logic       ped_served = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_input_conditioner_if bus ();

  assign bus.car_sensor_raw     = raw[0];
  assign bus.pedestrian_btn_raw = raw[1];
  assign bus.emergency_raw      = raw[2];
  assign bus.car_enter_raw      = raw[3];
  assign bus.car_exit_raw       = raw[4];
  assign bus.low_traffic_raw    = raw[5];
  assign bus.ped_served         = ped_served;

  traffic_input_conditioner #(.DEBOUNCE_CYCLES(DB), .EMERG_HOLD(EH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tic     (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model: synced history window per channel plus request/episode flags
  logic [5:0]  m_s1, m_s2, m_clean;
  logic [14:0] m_hist [6];
  logic        m_enter, m_exit, m_pend, m_serv, m_e_act;
  int          m_e_age, m_cnt;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_clean = '0;
    for (int ch = 0; ch < 6; ch++) m_hist[ch] = '0;
    m_enter = 0; m_exit = 0; m_pend = 0; m_serv = 0; m_e_act = 0;
    m_e_age = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [5:0] clean_pre;
    logic [5:0] rise;
    clean_pre = m_clean;
    rise      = '0;
    for (int ch = 0; ch < 6; ch++) begin
      m_hist[ch] = {m_hist[ch][13:0], m_s2[ch]};
      if (((m_hist[ch] ^ {15{clean_pre[ch]}}) & DB_MASK) == DB_MASK) begin
        m_clean[ch] = m_s2[ch];
        rise[ch]    = m_s2[ch];
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
    m_enter = rise[3] & ~rise[4];
    m_exit  = rise[4] & ~rise[3];
    if (m_pend) begin
      if (ped_served) begin m_pend = 0; m_serv = 1; end
    end else if (m_serv) begin
      if (!ped_served) m_serv = 0;
    end else if (rise[1]) begin
      m_pend = 1;
    end
    if (!m_e_act) begin
      if (rise[2]) begin
        m_e_act = 1;
        m_e_age = 0;
`ifdef TRAFFIC_STATS_EN
        if (m_cnt < 255) m_cnt++;
`endif
      end
    end else begin
      m_e_age++;
      if (m_e_age >= EH) m_e_act = clean_pre[2];
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("car_sensor",       32'(bus.car_sensor),       32'(m_clean[0]));
    chk("low_traffic_mode", 32'(bus.low_traffic_mode), 32'(m_clean[5]));
    chk("car_enter",        32'(bus.car_enter),        32'(m_enter));
    chk("car_exit",         32'(bus.car_exit),         32'(m_exit));
    chk("pedestrian_req",   32'(bus.pedestrian_req),   32'(m_pend));
    chk("emergency",        32'(bus.emergency),        32'(m_e_act));
    chk("emergency_count",  32'(bus.emergency_count),  32'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset();
    else          model_step();
    #2;
    compare();
  endtask

  task automatic pulse_reset();
    #1 reset_n = 1'b0;
    #1 model_reset();
    compare();
    #1 reset_n = 1'b1;
  endtask

  function automatic logic get_out(input int sel);
    case (sel)
      0:       return bus.car_sensor;
      1:       return bus.pedestrian_req;
      2:       return bus.emergency;
      3:       return bus.car_enter;
      4:       return bus.car_exit;
      default: return bus.low_traffic_mode;
    endcase
  endfunction

  typedef struct {
    logic [5:0] in_mask;
    int         len;
    int         gap;
    int         sel_out;
    int         exp_high;
    int         exp_first;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  initial begin
    int high;
    int first;

    vecs[0] = '{6'b000001,  2, 10, 0,  0, -1};  // glitch rejected
    vecs[1] = '{6'b000001, 10, 10, 0, 10,  5};  // 2 sync + 3 debounce
    vecs[2] = '{6'b000001,  3, 10, 0,  3,  5};  // shortest accepted run
    vecs[3] = '{6'b100000,  6, 10, 5,  6,  5};
    vecs[4] = '{6'b001000, 20, 10, 3,  1,  5};  // held input, one pulse
    vecs[5] = '{6'b010000,  4, 10, 4,  1,  5};
    vecs[6] = '{6'b011000, 10, 10, 3,  0, -1};  // simultaneous enter/exit
    vecs[7] = '{6'b000100,  3, 20, 2,  8,  5};  // minimum hold
    vecs[8] = '{6'b000100,  9, 20, 2, 10,  5};
    vecs[9] = '{6'b000100, 20, 30, 2, 21,  5};  // tracks clean level

    model_reset();
    repeat (2) @(posedge clk);
    #2;
    compare();
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      high  = 0;
      first = -1;
      for (int t = 1; t <= vecs[i].len + vecs[i].gap; t++) begin
        raw = (t <= vecs[i].len) ? vecs[i].in_mask : 6'd0;
        tick();
        if (get_out(vecs[i].sel_out)) begin
          high++;
          if (first < 0) first = t;
        end
      end
      chk($sformatf("vec%0d_high_cycles", i), 32'(high), 32'(vecs[i].exp_high));
      chk($sformatf("vec%0d_first_edge", i), 32'(first), 32'(vecs[i].exp_first));
    end

    // Pedestrian handshake
    ped_served = 0;
    raw[1] = 1; repeat (8) tick(); raw[1] = 0;
    repeat (50) tick();
    chk("ped_req_held", 32'(bus.pedestrian_req), 32'd1);
    raw[1] = 1; repeat (6) tick(); raw[1] = 0;
    repeat (10) tick();
    chk("ped_req_merged", 32'(bus.pedestrian_req), 32'd1);
    ped_served = 1; tick();
    chk("ped_req_served", 32'(bus.pedestrian_req), 32'd0);
    repeat (5) tick();
    ped_served = 0; repeat (3) tick();
    chk("ped_req_idle", 32'(bus.pedestrian_req), 32'd0);
    raw[1] = 1; repeat (8) tick(); raw[1] = 0;
    chk("ped_req_rearm", 32'(bus.pedestrian_req), 32'd1);
    ped_served = 1; repeat (3) tick();
    ped_served = 0; repeat (8) tick();
    ped_served = 1; raw[1] = 1;
    repeat (4) tick();
    chk("ped_preserved_before", 32'(bus.pedestrian_req), 32'd0);
    tick();
    chk("ped_preserved_req", 32'(bus.pedestrian_req), 32'd1);
    tick();
    chk("ped_preserved_clear", 32'(bus.pedestrian_req), 32'd0);
    raw[1] = 0; ped_served = 0;
    repeat (10) tick();

    // Reset while a request is pending and the emergency hold is running
    raw[1] = 1; repeat (6) tick(); raw[1] = 0;
    raw[2] = 1; repeat (6) tick(); raw[2] = 0;
    chk("pre_rst_ped", 32'(bus.pedestrian_req), 32'd1);
    chk("pre_rst_emerg", 32'(bus.emergency), 32'd1);
    pulse_reset();
    chk("rst_ped", 32'(bus.pedestrian_req), 32'd0);
    chk("rst_emerg", 32'(bus.emergency), 32'd0);
    repeat (15) tick();
    chk("post_rst_ped", 32'(bus.pedestrian_req), 32'd0);
    chk("post_rst_emerg", 32'(bus.emergency), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < 6; ch++)
        if ($urandom_range(7) == 0) raw[ch] = ~raw[ch];
      if ($urandom_range(9) == 0) ped_served = ~ped_served;
      tick();
    end

    // Emergency event statistics
    raw = 6'd0; ped_served = 0;
    pulse_reset();
    for (int e = 0; e < 300; e++) begin
      raw[2] = 1; repeat (4) tick();
      raw[2] = 0; repeat (14) tick();
    end
    chk("emergency_count_final", 32'(bus.emergency_count), 32'(EXP_FINAL_CNT));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/traffic_input_conditioner.md
Name: traffic_input_conditioner

Overview:
- Front-end stage feeding smart_traffic_controller.
- Takes raw, asynchronous field inputs: loop detector, pedestrian push-button, emergency pre-emption, parking gate sensors and the low-traffic mode switch.
- Synchronises and debounces each one, then produces the clean levels, single-cycle pulses and latched requests the controller consumes.
- Owns the pedestrian request handshake: a request is held until the controller reports the walk phase was served.

Parameters:
- DEBOUNCE_CYCLES, 3, consecutive synchronised cycles an input must hold a new value before the clean output changes (legal range 1..15).
- EMERG_HOLD, 8, minimum cycles emergency_out stays high once asserted (legal range 1..255).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- car_sensor_raw  in  1  raw vehicle loop detector
- pedestrian_btn_raw  in  1  raw push-button
- emergency_raw  in  1  raw pre-emption input
- car_enter_raw  in  1  raw parking entry gate sensor
- car_exit_raw  in  1  raw parking exit gate sensor
- low_traffic_raw  in  1  raw mode switch
- ped_served  in  1  walk phase active; driven from the controller's pedestrian_green
- car_sensor  out  1  debounced level
- pedestrian_req  out  1  latched request, held until served
- emergency  out  1  qualified emergency level
- car_enter  out  1  one-cycle pulse
- car_exit  out  1  one-cycle pulse
- low_traffic_mode  out  1  debounced level
- emergency_count  out  8  saturating emergency event count (see Optional Feature)

Behaviour:
- Reset: while reset_n is low, every flop clears and every output is 0; there is no partial state. Deassertion takes effect at the next clk edge.
- Sync: each raw input passes through 2 flops.
- Debounce, per channel, with a 4-bit counter and a clean register:
  - synced == clean: counter cleared.
  - synced != clean: counter increments; on reaching DEBOUNCE_CYCLES, clean takes synced and counter clears.
  - Any mismatch run shorter than DEBOUNCE_CYCLES is discarded.
- Latency: a raw change that is stable from edge k appears on the clean output after edge k+1+DEBOUNCE_CYCLES.
- car_sensor and low_traffic_mode are the clean levels, registered.
- car_enter / car_exit:
  - Registered pulse, high for exactly 1 cycle, asserted on the edge where the clean level rises.
  - Falling edges produce no pulse.
  - A held input produces exactly one pulse.
  - Both pulses due in the same cycle: both are suppressed and neither is asserted.
- Pedestrian FSM:
  - P_IDLE: rising edge of the clean button -> P_PENDING.
  - P_PENDING: pedestrian_req = 1. When ped_served = 1 -> P_SERVING and pedestrian_req = 0 on the same edge.
  - P_SERVING: when ped_served = 0 -> P_IDLE.
  - Presses in P_PENDING or P_SERVING are merged and never queued.
  - If ped_served is already high when a press arrives in P_IDLE, go to P_PENDING anyway; the request clears next cycle.
- Emergency FSM:
  - E_IDLE: rising edge of the clean emergency -> E_HOLD, load the hold counter with EMERG_HOLD-1, emergency = 1.
  - E_HOLD: decrement each cycle. At 0: -> E_TRACK if the clean level is high, else -> E_IDLE.
  - E_TRACK: emergency = 1 while the clean level is high; when it falls -> E_IDLE.
  - A new rising edge during E_HOLD does not reload the counter.
  - emergency is high in every state except E_IDLE.
- reset_n asserted mid-operation: the pending pedestrian request and any emergency hold are dropped.

Optional Feature:
- Macro: TRAFFIC_STATS_EN.
- Defined: emergency_count increments on each E_IDLE->E_HOLD transition and saturates at 255. It is cleared only by reset.
- Not defined: emergency_count is tied to 8'd0 and no counter logic exists. The port list is identical in both builds.

Test Plan:
- Glitch rejection. DEBOUNCE_CYCLES=3; 2-cycle high pulse on car_sensor_raw -> car_sensor stays 0. Then hold high 10 cycles -> car_sensor rises exactly 5 edges after the raw rise (2 sync + 3 debounce).
- Parking pulses:
  - car_enter_raw held high for 20 cycles -> car_enter is high for exactly 1 cycle.
  - car_enter_raw and car_exit_raw rising on the same edge, both held 10 cycles -> neither pulse is asserted.
- Pedestrian handshake:
  - Press the button (8 cycles) -> pedestrian_req = 1 and stays 1 for 50 cycles with ped_served = 0.
  - A second press meanwhile causes no change.
  - Raise ped_served -> pedestrian_req = 0 on the next edge.
  - Drop ped_served, press again -> request re-asserts.
- Emergency minimum hold. EMERG_HOLD=8:
  - Clean emergency high for 3 cycles -> emergency is high for exactly 8 cycles.
  - Clean emergency high for 20 cycles -> emergency stays high until the clean level falls, then drops on the next edge.
- Reset mid-operation: pedestrian_req = 1 and emergency in E_HOLD; pulse reset_n low between edges -> all outputs 0 immediately, with no request after release.
- Stats, with TRAFFIC_STATS_EN defined: 300 emergency events -> emergency_count = 255. With the macro undefined -> emergency_count stays 0.
